// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: RV32I funct3
//               widths, FSM states, fault codes and the request fault decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'b00,
        FLT_MIS   = 2'b01,
        FLT_RANGE = 2'b10,
        FLT_ILL   = 2'b11
    } lsu_fault_e;

    // Priority: illegal width, then alignment, then address range.
    function automatic lsu_fault_e decode_fault(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int unsigned mem_words
    );
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                   || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= mem_words);
        if (illegal) begin
            decode_fault = FLT_ILL;
        end else if (misaligned) begin
            decode_fault = FLT_MIS;
        end else if (out_of_range) begin
            decode_fault = FLT_RANGE;
        end else begin
            decode_fault = FLT_NONE;
        end
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Core request/response and data-memory signals of the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output busy, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  busy, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface : load_store_unit_if
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Little-endian lane logic: load extract/extend and sub-word
//               store merge into the read word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  wire logic [2:0]  funct3_i,
    input  wire logic [1:0]  lane_i,
    input  wire logic [31:0] mem_word_i,
    input  wire logic [31:0] st_data_i,
    output logic      [31:0] ld_data_o,
    output logic      [31:0] merged_o
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_shamt;
    logic [31:0] w_mask;
    logic [31:0] w_st_data;

    always_comb begin
        w_shifted = mem_word_i >> {lane_i, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = lane_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

        ld_data_o = 32'h0;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   ld_data_o = {24'h0, w_byte};
            F3_H:    ld_data_o = {{16{w_half[15]}}, w_half};
            F3_HU:   ld_data_o = {16'h0, w_half};
            F3_W:    ld_data_o = mem_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

    // Halfword stores only use lane bit 1; the alignment check already
    // rejected odd halfword addresses.
    always_comb begin
        if (funct3_i == F3_H) begin
            w_shamt   = {lane_i[1], 4'b0000};
            w_st_data = {16'h0, st_data_i[15:0]};
            w_mask    = 32'h0000_FFFF << w_shamt;
        end else begin
            w_shamt   = {lane_i, 3'b000};
            w_st_data = {24'h0, st_data_i[7:0]};
            w_mask    = 32'h0000_00FF << w_shamt;
        end
        merged_o = (mem_word_i & ~w_mask) | ((w_st_data << w_shamt) & w_mask);
    end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Sequential LSU between execute and a word-addressed data
//               memory; sub-word stores run as read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned IDX_W     = 6
) (
    input  wire logic       clk,
    input  wire logic       reset,
    load_store_unit_if.slave bus
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  resp_fault_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        mem_re_q;

    lsu_fault_e  w_fault;
    logic [31:0] w_ld_data;
    logic [31:0] w_merged;

    assign w_fault = decode_fault(bus.req_we, bus.req_funct3, bus.req_addr, MEM_WORDS);

    lsu_lane_align u_lane_align (
        .funct3_i   (funct3_q),
        .lane_i     (lane_q),
        .mem_word_i (bus.mem_rdata),
        .st_data_i  (wdata_q),
        .ld_data_o  (w_ld_data),
        .merged_o   (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 2'b00;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q     <= bus.req_funct3;
                        lane_q       <= bus.req_addr[1:0];
                        wdata_q      <= bus.req_wdata;
                        busy_q       <= 1'b1;
                        resp_rdata_q <= 32'h0;
                        resp_fault_q <= w_fault;
                        if (w_fault != FLT_NONE) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            mem_addr_q <= {{(32-IDX_W){1'b0}}, bus.req_addr[IDX_W+1:2]};
                            if (!bus.req_we) begin
                                state_q  <= ST_LOAD;
                                mem_re_q <= 1'b1;
                            end else if (bus.req_funct3 == F3_W) begin
                                state_q     <= ST_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state_q  <= ST_RMW_RD;
                                mem_re_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata_q <= w_ld_data;
                    mem_re_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_wdata_q <= w_merged;
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b1;
                    state_q     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_re_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a behavioural
//               memory/reference model and randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int NWORDS = 64;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_issue = 0;
    int   n_resp = 0;

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    exp_t        exp_q[$];
    wr_t         wq[$];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(64), .IDX_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = (bus.mem_addr < NWORDS) ? mem[bus.mem_addr[5:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_addr < NWORDS)) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: applies the architectural rules to ref_mem and predicts the response.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   size;
        logic bad_f3;
        logic [31:0] word;
        logic [31:0] raw;
        int   idx;
        size   = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        bad_f3 = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7});
        idx    = int'(addr >> 2);
        e.rdata = 32'h0;
        e.acc   = 0;
        if (bad_f3)                        e.fault = 2'b11;
        else if ((addr % size) != 0)       e.fault = 2'b01;
        else if ((addr >> 2) >= NWORDS)    e.fault = 2'b10;
        else                               e.fault = 2'b00;
        if (e.fault != 2'b00) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            word  = ref_mem[idx];
            raw   = 32'h0;
            for (int k = 0; k < size; k++) raw[8*k +: 8] = word[8*(int'(addr[1:0]) + k) +: 8];
            if (size == 4)      e.rdata = raw;
            else if (f3[2])     e.rdata = raw;
            else if (size == 1) e.rdata = {{24{raw[7]}}, raw[7:0]};
            else                e.rdata = {{16{raw[15]}}, raw[15:0]};
        end else begin
            e.lat = (size == 4) ? 2 : 3;
            word  = ref_mem[idx];
            for (int k = 0; k < size; k++) word[8*(int'(addr[1:0]) + k) +: 8] = wd[8*k +: 8];
            ref_mem[idx] = word;
            wq.push_back('{addr: 32'(idx), data: word});
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        while (bus.busy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.busy) begin
            check("accept_timeout", 32'd1, 32'd0);
            return;
        end
        e = model(we, f3, addr, wd);
        e.acc = cyc;
        @(posedge clk);
        exp_q.push_back(e);
        n_issue++;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops predictions on each response and tracks memory writes.
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].fault != 2'b00)
                check("fault_no_mem_access", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_mem_we", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("mem_addr", bus.mem_addr, w.addr);
                    check("mem_wdata", bus.mem_wdata, w.data);
                end
            end
            if (bus.resp_valid) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_fault", {30'h0, bus.resp_fault}, {30'h0, e.fault});
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},       {31'h0, bus.busy},       32'h0);
        check({tag, "_resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
        check({tag, "_mem_we"},     {31'h0, bus.mem_we},     32'h0);
        check({tag, "_mem_re"},     {31'h0, bus.mem_re},     32'h0);
        check({tag, "_resp_rdata"}, bus.resp_rdata,          32'h0);
        check({tag, "_resp_fault"}, {30'h0, bus.resp_fault}, 32'h0);
        check({tag, "_mem_addr"},   bus.mem_addr,            32'h0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,           32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;
        int          waited;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Directed sequence from the bring-up plan.
        issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        issue(1'b1, 3'b000, 32'h9, 32'h0000_0055);
        issue(1'b0, 3'b000, 32'hB, 32'h0);
        issue(1'b0, 3'b100, 32'hB, 32'h0);
        issue(1'b0, 3'b001, 32'hA, 32'h0);
        issue(1'b0, 3'b101, 32'h8, 32'h0);
        issue(1'b1, 3'b001, 32'h5, 32'h1234);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        issue(1'b0, 3'b011, 32'h4, 32'h0);
        idle(4);
        check("word2_after_sb", ref_mem[2], 32'hDEAD55EF);

        // Reset during the RMW_RD cycle of SH 0x4 must abort with no write.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h4;
        bus.req_wdata  = 32'h0000_A5A5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmw_rd_mem_re", {31'h0, bus.mem_re}, 32'h1);
        #2 reset = 1'b1;
        #1 check_outputs_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        check("word1_untouched", mem[1], ref_mem[1]);
        issue(1'b0, 3'b010, 32'h4, 32'h0);

        // Randomized stream; back-to-back issues keep req_valid high across busy.
        for (int n = 0; n < 300; n++) begin
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) f3 = 3'($urandom);
            else if (we)                    f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else                           addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'((f3[1:0] == 2'd0) ? 0 : ((f3[1:0] == 2'd1) ? 1 : 3));
            issue(we, f3, addr, $urandom);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 3));
        end

        idle(1);
        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        idle(3);
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        check("pending_writes", 32'(wq.size()), 32'd0);
        check("resp_count", 32'(n_resp), 32'(n_issue));
        for (int i = 0; i < NWORDS; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequential load/store unit between the core's execute stage and the word-addressed 64x32 data memory. It accepts byte, halfword and word loads/stores (RV32I funct3) at byte addresses and converts them to word-index accesses. Sub-word stores become read-modify-write sequences. Loads are extracted and sign/zero-extended, and illegal, misaligned or out-of-range requests are reported with a fault code. The core stalls on busy.

Parameters:
MEM_WORDS, 64, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range
IDX_W, 6, width of the word index driven on mem_addr low bits (clog2(MEM_WORDS))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present; accepted only when busy=0
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data; low byte/half used for SB/SH
busy  out  1  state != IDLE; core must hold/stall
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3; valid with resp_valid
mem_addr  out  32  word index, zero-extended (req_addr[31:2])
mem_wdata  out  32  word to write
mem_we  out  1  memory write enable, sampled by memory at clk rising edge
mem_re  out  1  memory read enable
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async): state=IDLE. busy, resp_valid, mem_we and mem_re = 0. resp_rdata, resp_fault, mem_addr and mem_wdata = 0. Reset mid-sequence aborts it, and no mem_we pulse is issued afterwards.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP. mem_re=1 only in LOAD/RMW_RD. mem_we=1 only in WRITE.
- Acceptance: the edge where state=IDLE and req_valid=1. The unit registers we, funct3, addr[1:0], word index and wdata, then decodes.
- Fault check at acceptance. Priority: illegal > misaligned > range.
  - Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - Out of range: addr[31:2] >= MEM_WORDS.
  - Faulted request goes straight to RESP. No memory access. resp_rdata=0.
- Load: IDLE->LOAD->RESP. In LOAD, drive mem_addr/mem_re and register the extracted mem_rdata at the end of the cycle. resp_valid=1 in RESP, which is the 2nd cycle after the acceptance edge.
- Extraction is little-endian. Byte lane = addr[1:0]; half lane = addr[1]. B/H sign-extend, BU/HU zero-extend, W passes through.
- SW: IDLE->WRITE->RESP. mem_wdata=req_wdata.
- SB/SH: IDLE->RMW_RD->WRITE->RESP. In RMW_RD, register a merge of mem_rdata with req_wdata[7:0]/[15:0] into the selected lane; other lanes are preserved. WRITE writes the merged word.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. busy=0 is visible in the cycle after RESP, so the earliest back-to-back accept is the edge ending the IDLE cycle.
- req_valid while busy is ignored, not queued. The core must hold it.
- mem_addr holds the last word index while IDLE. mem_wdata holds its value outside WRITE.
- Latency: load 2, SW 2, SB/SH 3, fault 1 (cycles from acceptance edge to resp_valid).

Decomposition:
- lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum encoding, fault codes (FLT_NONE/MIS/RANGE/ILL).
- One sub-module, lsu_lane_align (combinational), holding both lane paths: extract+extend for loads, merge for stores.
- FSM and registers stay in load_store_unit.

Test Plan:
- SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> one mem_we pulse at mem_addr=2 with mem_wdata=0xDEADBEEF; load resp_rdata=0xDEADBEEF, fault 00, resp_valid 2 cycles after accept.
- Word 2=0xDEADBEEF; SB 0x9 data 0x55 -> RMW_RD then WRITE; word 2 becomes 0xDEAD55EF; latency 3.
- Word 2=0xDEAD55EF: LB 0xB -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0xA -> 0xFFFFDEAD; LHU 0x8 -> 0x000055EF.
- SH 0x5 -> fault 01; LW 0x100 (index 64) -> fault 10; load funct3 011 -> fault 11. Each: resp_valid 1 cycle after accept, mem_we/mem_re never asserted, resp_rdata=0.
- Assert reset during the RMW_RD cycle of SH 0x4 -> all outputs 0 immediately, no mem_we, memory word 1 unchanged; next request after reset release accepted normally.
- req_valid held high across busy with a second different request -> only one accept per sequence; second accepted in IDLE; exactly one resp_valid per request.
